// File: rtl/dbg_ctrl.sv
// Debug/run controller: clock-enable gating, breakpoint, register dump.
// Optional DBG_CYCLE_CNT_EN adds cyc_cnt and a trailing cycle-count dump word.
module dbg_ctrl #(
    parameter int         NREG      = 16,
    parameter int         OB_LAT    = 1,
    parameter logic [2:0] DUMP_MODE = 3'b001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic        bp_en,
    input  logic [15:0] bp_addr,
    input  logic [15:0] pc_i,
    output logic        cpu_en,
    output logic        halted,
    output logic        bp_hit,
    output logic [3:0]  ob_sel,
    output logic [2:0]  ob_mode,
    input  logic [15:0] ob_data_i,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [15:0] dump_data,
    output logic [3:0]  dump_idx,
    output logic        dump_last
`ifdef DBG_CYCLE_CNT_EN
    ,
    output logic [31:0] cyc_cnt
`endif
);

    localparam logic [1:0] OP_HALT = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    localparam logic [1:0] OP_DUMP = 2'b11;

    localparam logic [3:0] LAST_IDX = 4'(NREG - 1);
    localparam logic [1:0] LAT_END  = 2'(OB_LAT - 1);

    typedef enum logic [2:0] {
        S_HALT,
        S_RUN,
        S_STEP,
        S_DUMP_SEL,
        S_DUMP_OUT
    } state_t;

    state_t      state;
    state_t      state_n;
    logic        bp_arm;
    logic        bp_match;
    logic        cmd_fire;
    logic [3:0]  idx;
    logic [1:0]  lat_cnt;
    logic        lat_done;
    logic        last_word;
    logic [15:0] cap_data;

    assign cmd_fire = cmd_valid & cmd_ready;
    assign bp_match = bp_en & (pc_i == bp_addr) & bp_arm;
    assign lat_done = (lat_cnt == LAT_END);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_HALT;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_HALT: begin
                if (cmd_fire) begin
                    unique case (cmd_op)
                        OP_RUN:  state_n = S_RUN;
                        OP_STEP: state_n = S_STEP;
                        OP_DUMP: state_n = S_DUMP_SEL;
                        default: state_n = S_HALT;
                    endcase
                end
            end
            S_RUN: begin
                if (bp_match || (cmd_fire && cmd_op == OP_HALT))
                    state_n = S_HALT;
            end
            S_STEP:     state_n = S_HALT;
            S_DUMP_SEL: if (lat_done) state_n = S_DUMP_OUT;
            S_DUMP_OUT: begin
                if (dump_ready)
                    state_n = last_word ? S_HALT : S_DUMP_SEL;
            end
            default:    state_n = S_HALT;
        endcase
    end

    always_comb begin
        cmd_ready  = 1'b0;
        cpu_en     = 1'b0;
        halted     = 1'b0;
        dump_valid = 1'b0;
        dump_last  = 1'b0;
        ob_sel     = 4'd0;
        ob_mode    = 3'd0;
        unique case (state)
            S_HALT: begin
                cmd_ready = 1'b1;
                halted    = 1'b1;
            end
            S_RUN: begin
                cmd_ready = 1'b1;
                cpu_en    = ~bp_match;
            end
            S_STEP: cpu_en = 1'b1;
            S_DUMP_SEL: begin
                ob_sel  = idx;
                ob_mode = DUMP_MODE;
            end
            S_DUMP_OUT: begin
                ob_sel     = idx;
                ob_mode    = DUMP_MODE;
                dump_valid = 1'b1;
                dump_last  = last_word;
            end
            default: ;
        endcase
    end

    // Arm drops on entry to RUN so a resume from the breakpoint PC advances.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bp_arm <= 1'b0;
            bp_hit <= 1'b0;
        end else begin
            bp_hit <= (state == S_RUN) && bp_match;
            if (state == S_HALT && state_n == S_RUN) bp_arm <= 1'b0;
            else if (state == S_RUN)                 bp_arm <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lat_cnt <= 2'd0;
        else if (state != S_DUMP_SEL || lat_done) lat_cnt <= 2'd0;
        else lat_cnt <= lat_cnt + 2'd1;
    end

`ifdef DBG_CYCLE_CNT_EN
    logic        xtra;
    logic [15:0] snap;

    assign last_word = xtra;
    assign cap_data  = xtra ? snap : ob_data_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_cnt <= 32'd0;
            snap    <= 16'd0;
            xtra    <= 1'b0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'(cpu_en);
            if (state == S_HALT && state_n == S_DUMP_SEL) begin
                snap <= cyc_cnt[15:0];
                xtra <= 1'b0;
            end else if (state == S_DUMP_OUT && dump_ready) begin
                xtra <= !xtra && (idx == LAST_IDX);
            end
        end
    end
`else
    assign last_word = (idx == LAST_IDX);
    assign cap_data  = ob_data_i;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx       <= 4'd0;
            dump_data <= 16'd0;
        end else begin
            if (state == S_HALT && state_n == S_DUMP_SEL)
                idx <= 4'd0;
            else if (state == S_DUMP_OUT && dump_ready) begin
                if (last_word)              idx <= 4'd0;
                else if (idx == LAST_IDX)   idx <= 4'hF;
                else                        idx <= idx + 4'd1;
            end
            if (state == S_DUMP_SEL && lat_done)
                dump_data <= cap_data;
        end
    end

    assign dump_idx = idx;

endmodule

// File: tb/tb_dbg_ctrl.sv
// Self-checking bench for dbg_ctrl: reset, step, breakpoint, run/halt, dump.
// Dump words are checked against a scoreboard queue filled at command issue.
module tb_dbg_ctrl;

    localparam int NREG = 16;
    localparam logic [1:0] OP_HALT = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    localparam logic [1:0] OP_DUMP = 2'b11;

    typedef struct packed {
        logic [3:0]  idx;
        logic [15:0] data;
        logic        last;
    } word_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic        bp_en = 1'b0;
    logic [15:0] bp_addr = 16'h0;
    logic [15:0] pc_i;
    logic        cpu_en;
    logic        halted;
    logic        bp_hit;
    logic [3:0]  ob_sel;
    logic [2:0]  ob_mode;
    logic [15:0] ob_data_i;
    logic        dump_valid;
    logic        dump_ready = 1'b0;
    logic [15:0] dump_data;
    logic [3:0]  dump_idx;
    logic        dump_last;
`ifdef DBG_CYCLE_CNT_EN
    logic [31:0] cyc_cnt;
`endif

    logic        pc_load = 1'b0;
    logic [15:0] pc_load_val = 16'h0;
    logic [31:0] tb_cyc;

    int total = 0;
    int bad = 0;
    word_t exp_q[$];

    dbg_ctrl #(.NREG(NREG), .OB_LAT(1), .DUMP_MODE(3'b001)) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .bp_en(bp_en),
        .bp_addr(bp_addr),
        .pc_i(pc_i),
        .cpu_en(cpu_en),
        .halted(halted),
        .bp_hit(bp_hit),
        .ob_sel(ob_sel),
        .ob_mode(ob_mode),
        .ob_data_i(ob_data_i),
        .dump_valid(dump_valid),
        .dump_ready(dump_ready),
        .dump_data(dump_data),
        .dump_idx(dump_idx),
        .dump_last(dump_last)
`ifdef DBG_CYCLE_CNT_EN
        ,
        .cyc_cnt(cyc_cnt)
`endif
    );

    always #5 clk = ~clk;

    assign ob_data_i = 16'hA000 + {12'h0, ob_sel};

    // Minimal CPU model: fetch address advances whenever enabled.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_i   <= 16'h0;
            tb_cyc <= 32'h0;
        end else begin
            tb_cyc <= tb_cyc + 32'(cpu_en);
            if (pc_load)     pc_i <= pc_load_val;
            else if (cpu_en) pc_i <= pc_i + 16'h1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] op);
        cmd_valid = 1'b1;
        cmd_op    = op;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic load_pc(input logic [15:0] v);
        pc_load     = 1'b1;
        pc_load_val = v;
        tick();
        pc_load = 1'b0;
    endtask

    task automatic push_dump();
        for (int i = 0; i < NREG; i++) begin
            word_t e;
            e.idx  = 4'(i);
            e.data = 16'hA000 + 16'(i);
            e.last = 1'b0;
`ifndef DBG_CYCLE_CNT_EN
            e.last = (i == NREG - 1);
`endif
            exp_q.push_back(e);
        end
`ifdef DBG_CYCLE_CNT_EN
        begin
            word_t c;
            c.idx  = 4'hF;
            c.data = tb_cyc[15:0];
            c.last = 1'b1;
            exp_q.push_back(c);
        end
`endif
    endtask

    task automatic check_word();
        word_t e;
        word_t got;
        got = {dump_idx, dump_data, dump_last};
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL dump_extra got=%h want=none", got);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                bad++;
                $display("FAIL dump_word got=%h want=%h", got, e);
            end
        end
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({halted, cpu_en, cmd_ready, dump_valid, ob_sel, ob_mode}
            !== {1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 3'h0}) begin
            bad++;
            $display("FAIL reset_held got=%b want=1010_0000_000",
                     {halted, cpu_en, cmd_ready, dump_valid, ob_sel, ob_mode});
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (6) tick();
        total++;
        if ({halted, cpu_en, cmd_ready, bp_hit, dump_valid, ob_sel, ob_mode}
            !== {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 3'h0}) begin
            bad++;
            $display("FAIL reset_idle got=%b",
                     {halted, cpu_en, cmd_ready, bp_hit, dump_valid, ob_sel, ob_mode});
        end
        total++;
        if ({dump_data, dump_idx, dump_last} !== 21'h0) begin
            bad++;
            $display("FAIL reset_dump got=%h want=0", {dump_data, dump_idx, dump_last});
        end
    endtask

    task automatic test_step();
        load_pc(16'h0010);
        send_cmd(OP_STEP);
        total++;
        if ({cpu_en, cmd_ready, halted} !== 3'b100) begin
            bad++;
            $display("FAIL step_active got=%b want=100", {cpu_en, cmd_ready, halted});
        end
        tick();
        total++;
        if ({cpu_en, halted} !== 2'b01) begin
            bad++;
            $display("FAIL step_done got=%b want=01", {cpu_en, halted});
        end
        tick();
        total++;
        if (pc_i !== 16'h0011 || cpu_en !== 1'b0) begin
            bad++;
            $display("FAIL step_pc got=%h/%b want=0011/0", pc_i, cpu_en);
        end
    endtask

    task automatic test_breakpoint();
        bit stopped;
        int hits;
        load_pc(16'h0000);
        bp_en   = 1'b1;
        bp_addr = 16'h0004;
        send_cmd(OP_RUN);
        stopped = 1'b0;
        hits = 0;
        for (int i = 0; i < 20 && !stopped; i++) begin
            if (bp_hit) hits++;
            if (!cpu_en) stopped = 1'b1;
            else tick();
        end
        total++;
        if (!stopped || pc_i !== 16'h0004 || halted !== 1'b0 || hits != 0) begin
            bad++;
            $display("FAIL bp_stop got pc=%h halted=%b hits=%0d stopped=%b want pc=0004 0 0 1",
                     pc_i, halted, hits, stopped);
        end
        tick();
        total++;
        if ({halted, bp_hit, cpu_en} !== 3'b110) begin
            bad++;
            $display("FAIL bp_hit got=%b want=110", {halted, bp_hit, cpu_en});
        end
        tick();
        total++;
        if (bp_hit !== 1'b0 || pc_i !== 16'h0004) begin
            bad++;
            $display("FAIL bp_pulse got=%b/%h want=0/0004", bp_hit, pc_i);
        end
        send_cmd(OP_RUN);
        total++;
        if (cpu_en !== 1'b1 || pc_i !== 16'h0004) begin
            bad++;
            $display("FAIL bp_resume got=%b/%h want=1/0004", cpu_en, pc_i);
        end
        tick();
        total++;
        if (pc_i !== 16'h0005) begin
            bad++;
            $display("FAIL bp_advance got=%h want=0005", pc_i);
        end
        bp_en = 1'b0;
        send_cmd(OP_HALT);
    endtask

    task automatic test_run_halt();
        send_cmd(OP_RUN);
        tick();
        total++;
        if ({cpu_en, halted, cmd_ready} !== 3'b101) begin
            bad++;
            $display("FAIL run_state got=%b want=101", {cpu_en, halted, cmd_ready});
        end
        send_cmd(OP_STEP);
        send_cmd(OP_DUMP);
        tick();
        total++;
        if ({cpu_en, halted, dump_valid, ob_mode} !== 6'b100000) begin
            bad++;
            $display("FAIL run_ignore got=%b want=100000",
                     {cpu_en, halted, dump_valid, ob_mode});
        end
        send_cmd(OP_HALT);
        total++;
        if ({cpu_en, halted} !== 2'b01) begin
            bad++;
            $display("FAIL run_halt got=%b want=01", {cpu_en, halted});
        end
    endtask

    task automatic run_dump();
        bit          done;
        bit          hold;
        logic [20:0] hold_w;
        push_dump();
        send_cmd(OP_DUMP);
        done = 1'b0;
        hold = 1'b0;
        hold_w = '0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            dump_ready = 1'($urandom_range(0, 1));
            total++;
            if (ob_mode !== 3'b001) begin
                bad++;
                $display("FAIL dump_mode got=%b want=001", ob_mode);
            end
            if (hold) begin
                total++;
                if ({dump_idx, dump_data, dump_last} !== hold_w || !dump_valid) begin
                    bad++;
                    $display("FAIL dump_hold got=%h want=%h",
                             {dump_idx, dump_data, dump_last}, hold_w);
                end
                hold = 1'b0;
            end
            if (dump_valid) begin
                if (dump_ready) begin
                    check_word();
                    if (dump_last) done = 1'b1;
                end else begin
                    hold   = 1'b1;
                    hold_w = {dump_idx, dump_data, dump_last};
                end
            end
            tick();
        end
        dump_ready = 1'b0;
        total++;
        if (!done || exp_q.size() != 0) begin
            bad++;
            $display("FAIL dump_end got done=%b left=%0d want 1/0", done, exp_q.size());
        end
        total++;
        if ({halted, dump_valid, ob_sel, ob_mode} !== 9'b1_0_0000_000) begin
            bad++;
            $display("FAIL dump_after got=%b want=100000000",
                     {halted, dump_valid, ob_sel, ob_mode});
        end
        exp_q.delete();
    endtask

    task automatic test_dump();
        run_dump();
    endtask

    task automatic test_reset_mid_dump();
        bit at7;
        push_dump();
        send_cmd(OP_DUMP);
        at7 = 1'b0;
        for (int cyc = 0; cyc < 200 && !at7; cyc++) begin
            if (dump_valid && dump_idx == 4'd7) begin
                at7 = 1'b1;
            end else begin
                dump_ready = dump_valid;
                if (dump_valid) check_word();
                tick();
            end
        end
        dump_ready = 1'b0;
        total++;
        if (!at7) begin
            bad++;
            $display("FAIL mid_reach got=0 want=1");
        end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if ({dump_valid, ob_sel, halted, dump_idx} !== 10'b0_0000_1_0000) begin
            bad++;
            $display("FAIL mid_reset got=%b want=0000010000",
                     {dump_valid, ob_sel, halted, dump_idx});
        end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        tick();
        run_dump();
    endtask

    initial begin
        test_reset();
        test_step();
        test_breakpoint();
        test_run_halt();
        test_dump();
        test_reset_mid_dump();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dbg_ctrl.md
Name: dbg_ctrl

Overview:
Debug/run controller for Naive_CPU. Gates CPU progress with a clock-enable and accepts halt/run/single-step/register-dump commands over a valid/ready port. Supports one PC breakpoint. For register dumps it sequences the CPU observer port (ob_sel/ob_mode/ob_data) and streams the register values out over a second valid/ready port.

Parameters:
NREG, 16, number of registers dumped (1..16); dump index runs 0..NREG-1
OB_LAT, 1, observer read latency in cycles between ob_sel change and valid ob_data_i (1..3)
DUMP_MODE, 3'b001, ob_mode value driven while dumping

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-low
cmd_valid  in  1  command valid
cmd_ready  out  1  command accept
cmd_op  in  2  00 HALT, 01 RUN, 10 STEP, 11 DUMP
bp_en  in  1  breakpoint enable
bp_addr  in  16  breakpoint PC
pc_i  in  16  CPU fetch address (rom_addr_o)
cpu_en  out  1  CPU advance enable; 0 = pipeline stalled
halted  out  1  1 in HALT state
bp_hit  out  1  one-cycle pulse on breakpoint stop
ob_sel  out  4  observer register select
ob_mode  out  3  observer mode
ob_data_i  in  16  observer data
dump_valid  out  1  dump word valid
dump_ready  in  1  dump word accept
dump_data  out  16  register value
dump_idx  out  4  register index of dump_data
dump_last  out  1  1 with the final dump word

Behaviour:
- Reset (rst=0, async): state HALT; cpu_en=0, halted=1, cmd_ready=1, bp_hit=0, ob_sel=0, ob_mode=0, dump_valid=0, dump_data=0, dump_idx=0, dump_last=0, bp_arm cleared. Reset mid-step or mid-dump aborts immediately; no partial dump words remain.
- States: HALT, RUN, STEP, DUMP_SEL, DUMP_OUT. A command is accepted on a clk edge with cmd_valid&cmd_ready.
- cmd_ready=1 in HALT and RUN; 0 in STEP, DUMP_SEL, DUMP_OUT.
- HALT: RUN->RUN; STEP->STEP; DUMP->DUMP_SEL with idx=0; HALT = no-op.
- RUN: HALT->HALT. RUN/STEP/DUMP are accepted and discarded.
- cpu_en is combinational: 1 in STEP; 1 in RUN unless bp_match. bp_match = bp_en & (pc_i==bp_addr) & bp_arm.
- bp_arm clears on HALT->RUN entry and sets after the first RUN cycle. Resuming from a breakpoint PC therefore advances at least once.
- bp_match in RUN: cpu_en=0 that cycle, next state HALT, bp_hit=1 for exactly the following cycle. Stall on the breakpoint instruction fetch. HALT command and bp_match in the same cycle: HALT, with bp_hit still pulsed.
- STEP: exactly one cycle with cpu_en=1 (breakpoint ignored), then HALT.
- DUMP_SEL: ob_mode=DUMP_MODE, ob_sel=idx. Wait OB_LAT cycles, capture ob_data_i into dump_data, go to DUMP_OUT.
- DUMP_OUT: dump_valid=1; dump_data/dump_idx/dump_last stable until dump_ready. dump_last=(idx==NREG-1).
- On transfer: if last, go to HALT with ob_sel=0, ob_mode=0, dump_valid=0. Otherwise idx+1 and back to DUMP_SEL.
- cpu_en=0 throughout DUMP.
- halted = (state==HALT).

Optional Feature:
DBG_CYCLE_CNT_EN. When defined, adds port cyc_cnt (out, 32): count of cycles with cpu_en=1. Reset to 0; wraps at 2^32-1 -> 0. When DUMP is executed, an extra dump word follows register NREG-1: cyc_cnt[15:0] with dump_idx=4'hF, and dump_last moves to this word. The count is snapshotted at DUMP acceptance. When undefined, the port and extra word are absent and dump_last is on register NREG-1.

Test Plan:
- Reset release, no commands -> halted=1, cpu_en=0 indefinitely, all outputs at reset values.
- STEP from HALT -> cpu_en high exactly 1 cycle, halted re-asserts the next cycle. cmd_ready=0 during STEP.
- RUN, bp_en=1, bp_addr=16'h0004, pc_i incrementing from 0 -> cpu_en drops the cycle pc_i=0004, bp_hit pulses once, halted=1. RUN again -> cpu_en=1 at pc_i=0004 (bp_arm masked), CPU proceeds to 0005.
- RUN then HALT command -> cpu_en=0 the cycle after acceptance. STEP and DUMP issued during RUN -> no effect.
- DUMP with NREG=16, OB_LAT=1, ob_data_i=16'hA000+ob_sel, dump_ready toggling 50% -> 16 words A000..A00F in order with idx 0..15; dump_last only on idx 15; ob_mode=001 during dump, 000 after.
- Assert rst during DUMP_OUT at idx 7 -> dump_valid=0, ob_sel=0, halted=1 asynchronously. The next DUMP restarts at idx 0.
